// File: rtl/multicycle_sequencer.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit CPU, with illegal-opcode and bus-timeout traps.
// Latency: with zero-wait memories, R/I-type 4 cycles, LW 5, SW 4, BEQ 3 (FETCH entry to next FETCH entry).
// Backpressure: FETCH and MEM hold their request until InstrReady/DataReady; after WAIT_MAX wait cycles the FSM traps with BusError.
//
// Ports:
//   Clock, Reset           rising-edge clock, asynchronous active-high reset
//   Run                    starts fetching; only looked at in IDLE
//   OPCode                 IR[15:12], captured in DECODE
//   Zero                   ALU zero flag, used by BEQ in EXEC
//   InstrReady, DataReady  memory completion strobes
//   InstrRead, IRWrite, PCWrite        fetch-side controls
//   RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp  datapath controls
//   Illegal, BusError      sticky trap flags
//   Retired                retired-instruction counter (wraps)
module multicycle_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [3:0]       OPCode,
  input  logic             Zero,
  input  logic             InstrReady,
  input  logic             DataReady,
  output logic             InstrRead,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             Illegal,
  output logic             BusError,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] TRAP   = 3'd6;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  logic [2:0] state;
  logic [2:0] nextState;
  logic [3:0] opReg;
  logic [7:0] waitCnt;

  logic waiting;
  logic readyNow;
  logic busTimeout;
  logic retire;

  function automatic logic isRType(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010};
  endfunction

  function automatic logic isIType(input logic [3:0] op);
    return op inside {4'b1001, 4'b1010, 4'b1011};
  endfunction

  function automatic logic isLoad(input logic [3:0] op);
    return op == 4'b1100;
  endfunction

  function automatic logic isStore(input logic [3:0] op);
    return op == 4'b1101;
  endfunction

  function automatic logic isBranch(input logic [3:0] op);
    return op == 4'b1111;
  endfunction

  function automatic logic isLegal(input logic [3:0] op);
    return isRType(op) || isIType(op) || isLoad(op) || isStore(op) || isBranch(op);
  endfunction

  // The wait counter holds the number of Ready-low cycles seen so far in
  // this FETCH/MEM visit. A timeout fires only when the count already equals
  // WAIT_MAX and Ready is still low, so a Ready in that same cycle completes.
  assign waiting    = (state == FETCH) || (state == MEM);
  assign readyNow   = (state == FETCH) ? InstrReady : DataReady;
  assign busTimeout = waiting && !readyNow && (waitCnt >= WAIT_LIMIT);

  assign retire = ((state == EXEC) && isBranch(opReg)) ||
                  ((state == MEM) && isStore(opReg) && DataReady) ||
                  (state == WB);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (Run) nextState = FETCH;
      FETCH: begin
        if (InstrReady)      nextState = DECODE;
        else if (busTimeout) nextState = TRAP;
      end
      DECODE: nextState = isLegal(OPCode) ? EXEC : TRAP;
      EXEC: begin
        if (isRType(opReg) || isIType(opReg))     nextState = WB;
        else if (isLoad(opReg) || isStore(opReg)) nextState = MEM;
        else if (isBranch(opReg))                 nextState = FETCH;
        else                                      nextState = TRAP;
      end
      MEM: begin
        if (DataReady)       nextState = isLoad(opReg) ? WB : FETCH;
        else if (busTimeout) nextState = TRAP;
      end
      WB:     nextState = FETCH;
      TRAP:   nextState = TRAP;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    InstrRead = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        InstrRead = 1'b1;
        // Branch stays 0 here, so the PC mux takes PC+2.
        IRWrite   = InstrReady;
        PCWrite   = InstrReady;
      end
      EXEC: begin
        if (isRType(opReg)) begin
          RegDst = 1'b1;
          ALUOp  = 2'b10;
        end else if (isIType(opReg)) begin
          ALUSrc = 1'b1;
          ALUOp  = 2'b11;
        end else if (isLoad(opReg) || isStore(opReg)) begin
          ALUSrc = 1'b1;
          ALUOp  = 2'b00;
        end else if (isBranch(opReg)) begin
          ALUOp   = 2'b01;
          Branch  = 1'b1;
          PCWrite = Zero;
        end
      end
      MEM: begin
        // Address operand stays selected for the whole access.
        ALUSrc   = 1'b1;
        MemRead  = isLoad(opReg);
        MemWrite = isStore(opReg);
      end
      WB: begin
        RegWrite = 1'b1;
        RegDst   = isRType(opReg);
        MemToReg = isLoad(opReg);
        ALUSrc   = isIType(opReg) || isLoad(opReg);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      opReg    <= 4'b0000;
      waitCnt  <= 8'd0;
      Illegal  <= 1'b0;
      BusError <= 1'b0;
      Retired  <= '0;
    end else begin
      state <= nextState;

      if (state == DECODE) begin
        opReg <= OPCode;
        if (!isLegal(OPCode)) Illegal <= 1'b1;
      end

      if (busTimeout) BusError <= 1'b1;

      if ((nextState != state) && ((nextState == FETCH) || (nextState == MEM)))
        waitCnt <= 8'd0;
      else if (waiting && !readyNow && !busTimeout)
        waitCnt <= waitCnt + 8'd1;

      if (retire) Retired <= Retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit CPU. It replaces single-cycle decoding with a sequenced FETCH/DECODE/EXEC/MEM/WB flow.
- It drives the same datapath control signals: RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp, Branch. It adds PC/IR write enables, ready/valid memory handshakes, a bus timeout, an illegal-opcode trap and a retired-instruction counter.
- It sits between the instruction/data memories and the register file/ALU datapath.

Parameters:
- WAIT_MAX, 15, maximum cycles spent waiting for InstrReady/DataReady before a bus-error trap (1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  enables instruction fetch; sampled only in IDLE.
- OPCode  in  4  IR[15:12], valid from DECODE onward.
- Zero  in  1  ALU zero flag, valid in EXEC.
- InstrReady  in  1  instruction memory completes the read this cycle.
- DataReady  in  1  data memory completes the access this cycle.
- InstrRead  out  1  instruction memory read request.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC (PC+2, or branch target when Branch=1).
- RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- ALUOp  out  2  ALU operation class.
- Illegal  out  1  sticky illegal-opcode trap.
- BusError  out  1  sticky handshake-timeout trap.
- Retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state, latched opcode (OpReg), wait counter (8 bit), Retired. All outputs decode from state, OpReg, Zero and the Ready inputs.
- Reset (async, any state, mid-access included): state=IDLE; OpReg=0; wait counter=0; Retired=0; Illegal=BusError=0; every control output 0. Default for each control in each state is 0, no X.
- IDLE: if Run=1, go to FETCH next cycle; else stay.
- FETCH: InstrRead=1, held until InstrReady.
  - In the InstrReady cycle: IRWrite=1, PCWrite=1 (Branch=0 selects PC+2), go to DECODE.
- DECODE: OpReg<=OPCode.
  - Legal opcodes {0000,0001,0010,1001,1010,1011,1100,1101,1111} go to EXEC.
  - Any other opcode: Illegal<=1, go to TRAP.
- EXEC, controls by OpReg:
  - R-type (0000/0001/0010): RegDst=1, ALUSrc=0, ALUOp=10. Next state WB.
  - I-type (1001/1010/1011): ALUSrc=1, ALUOp=11. Next state WB.
  - LW/SW (1100/1101): ALUSrc=1, ALUOp=00. Next state MEM.
  - BEQ (1111): ALUOp=01, Branch=1, PCWrite=Zero. Next state FETCH; the instruction retires.
- MEM: ALUSrc=1 held.
  - LW: MemRead=1 until DataReady, then go to WB.
  - SW: MemWrite=1 until DataReady, then go to FETCH and retire. MemWrite stays asserted through the DataReady cycle and drops the next cycle.
- WB: RegWrite=1 for exactly one cycle.
  - RegDst=1 for R-type.
  - MemToReg=1 for LW.
  - ALUSrc=1 for I-type and LW.
  - Next state FETCH; the instruction retires.
- Latency (zero-wait memories): R/I-type 4 cycles, LW 5, SW 4, BEQ 3, counted from FETCH entry to the next FETCH entry.
- Run is ignored outside IDLE. The FSM returns to FETCH, not IDLE, after each instruction.
- Retired increments by 1 on each retire event and wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entering FETCH or MEM.
  - Increments each cycle while in FETCH or MEM with the relevant Ready low.
  - If it reaches WAIT_MAX with Ready still low: BusError<=1, go to TRAP, drop the request.
  - A Ready arriving in the same cycle the count hits WAIT_MAX wins: the access completes with no error.
- TRAP: all controls 0. Remains until Reset. Illegal and BusError hold their values.
- Ready inputs are ignored in states that are not waiting on them.

Test Plan:
- R-type ADD (0001), InstrReady tied 1 -> IRWrite+PCWrite pulse in cycle 1, RegWrite=1 with RegDst=1 in cycle 4, Retired 0->1.
- LW (1100), DataReady delayed 3 cycles -> MemRead high 4 cycles, then WB with MemToReg=1 and RegWrite=1, Retired=1. SW (1101) -> MemWrite high until DataReady, RegWrite never 1.
- BEQ with Zero=1 then Zero=0 -> EXEC shows Branch=1, ALUOp=01; PCWrite=1 only in the Zero=1 case; 3 cycles each.
- Opcode 0101 -> Illegal=1 after DECODE, TRAP, all controls 0 for 20+ cycles; Reset clears Illegal and returns to IDLE.
- InstrReady held 0, WAIT_MAX=15 -> BusError=1 after 15 wait cycles. Repeat with InstrReady arriving exactly at count 15 -> no error, DECODE entered.
- Reset asserted mid-MEM with MemWrite=1 -> MemWrite drops asynchronously, state IDLE, Retired=0.
